// File: rtl/io_bus_arbiter.sv
// Two-master arbiter and sequencer for the shared 16-bit peripheral I/O bus.
// One transaction at a time: IDLE -> ISSUE -> (WAIT) -> DONE, with an ack pulse in DONE.
module io_bus_arbiter #(
    parameter int unsigned RD_LAT     = 1,
    parameter bit          PRIO_FIXED = 1'b0
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [15:0] m0_addr,
    input  logic [15:0] m0_wdata,
    output logic        m0_ack,
    output logic [15:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [15:0] m1_addr,
    input  logic [15:0] m1_wdata,
    output logic        m1_ack,
    output logic [15:0] m1_rdata,
    output logic        io_rd,
    output logic        io_wr,
    output logic [15:0] io_addr,
    output logic [15:0] io_dout,
    input  logic [15:0] io_din,
    output logic [1:0]  grant,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [1:0] LAT2 = 2'(RD_LAT);

    state_t      state_q, state_d;
    logic        wr_q, wr_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_q, last_d;    // 1 = master 1 was granted last
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] rdata0_q, rdata0_d;
    logic [15:0] rdata1_q, rdata1_d;
    logic        pick1;

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            state_q  <= IDLE;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            grant_q  <= '0;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Master 1 wins when alone, or on a tie under round-robin when master 0 went last.
    assign pick1 = m1_req & (~m0_req | (~PRIO_FIXED & ~last_q));

    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        grant_d  = grant_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        io_rd    = 1'b0;
        io_wr    = 1'b0;
        io_addr  = '0;
        io_dout  = '0;
        m0_ack   = 1'b0;
        m1_ack   = 1'b0;

        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (m0_req || m1_req) begin
                    wr_d    = pick1 ? m1_wr    : m0_wr;
                    addr_d  = pick1 ? m1_addr  : m0_addr;
                    wdata_d = pick1 ? m1_wdata : m0_wdata;
                    grant_d = pick1 ? 2'b10 : 2'b01;
                    last_d  = pick1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                io_addr = addr_q;
                if (wr_q) begin
                    io_wr   = 1'b1;
                    io_dout = wdata_q;
                    if (grant_q[0]) rdata0_d = '0;
                    else            rdata1_d = '0;
                    state_d = DONE;
                end else begin
                    io_rd = 1'b1;
                    if (RD_LAT == 0) begin
                        if (grant_q[0]) rdata0_d = io_din;
                        else            rdata1_d = io_din;
                        state_d = DONE;
                    end else begin
                        cnt_d   = LAT2;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                io_addr = addr_q;
                cnt_d   = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    if (grant_q[0]) rdata0_d = io_din;
                    else            rdata1_d = io_din;
                    state_d = DONE;
                end
            end
            DONE: begin
                m0_ack  = grant_q[0];
                m1_ack  = grant_q[1];
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;
    assign grant    = grant_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Scoreboard bench for io_bus_arbiter: four instances (RD_LAT 1/0/3 round-robin, RD_LAT 1 fixed
// priority) share stimulus; the monitor checks bus strobes and acks of the selected instance.
module tb_io_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 1'b0, m0_wr = 1'b0, m1_req = 1'b0, m1_wr = 1'b0;
    logic [15:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic [15:0] io_din = 16'hDEAD;

    logic        m0_ack_w [4];
    logic        m1_ack_w [4];
    logic [15:0] m0_rdata_w [4];
    logic [15:0] m1_rdata_w [4];
    logic        io_rd_w [4];
    logic        io_wr_w [4];
    logic [15:0] io_addr_w [4];
    logic [15:0] io_dout_w [4];
    logic [1:0]  grant_w [4];
    logic        busy_w [4];

    int sel = 0;
    int cyc = 0;
    int nvec = 0;
    int nmis = 0;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] dout;
        int          cyc;
    } bus_t;

    typedef struct {
        logic [1:0]  who;
        logic [15:0] rdata;
        int          cyc;
    } ack_t;

    bus_t busq[$];
    ack_t ackq[$];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        io_bus_arbiter #(
            .RD_LAT    ((g == 1) ? 0 : ((g == 2) ? 3 : 1)),
            .PRIO_FIXED((g == 3) ? 1'b1 : 1'b0)
        ) u_dut (
            .sys_clk_i(clk),
            .sys_rst_i(rst_n),
            .m0_req   (m0_req),
            .m0_wr    (m0_wr),
            .m0_addr  (m0_addr),
            .m0_wdata (m0_wdata),
            .m0_ack   (m0_ack_w[g]),
            .m0_rdata (m0_rdata_w[g]),
            .m1_req   (m1_req),
            .m1_wr    (m1_wr),
            .m1_addr  (m1_addr),
            .m1_wdata (m1_wdata),
            .m1_ack   (m1_ack_w[g]),
            .m1_rdata (m1_rdata_w[g]),
            .io_rd    (io_rd_w[g]),
            .io_wr    (io_wr_w[g]),
            .io_addr  (io_addr_w[g]),
            .io_dout  (io_dout_w[g]),
            .io_din   (io_din),
            .grant    (grant_w[g]),
            .busy     (busy_w[g])
        );
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_bus(input bit wr, input logic [15:0] a, input logic [15:0] d, input int c);
        bus_t e;
        e.wr = wr; e.addr = a; e.dout = d; e.cyc = c;
        busq.push_back(e);
    endtask

    task automatic push_ack(input logic [1:0] who, input logic [15:0] rd, input int c);
        ack_t e;
        e.who = who; e.rdata = rd; e.cyc = c;
        ackq.push_back(e);
    endtask

    // Monitor: every strobe and every ack of the selected instance must match the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (io_rd_w[sel] || io_wr_w[sel]) begin
                bus_t e;
                nvec++;
                if (busq.size() == 0) begin
                    nmis++;
                    $display("FAIL bus: unexpected strobe rd=%0d wr=%0d addr=%h cyc %0d",
                             io_rd_w[sel], io_wr_w[sel], io_addr_w[sel], cyc);
                end else begin
                    e = busq.pop_front();
                    if (io_rd_w[sel] == e.wr || io_wr_w[sel] != e.wr ||
                        io_addr_w[sel] !== e.addr || io_dout_w[sel] !== e.dout || cyc != e.cyc) begin
                        nmis++;
                        $display("FAIL bus: got rd=%0d wr=%0d addr=%h dout=%h cyc=%0d want wr=%0d addr=%h dout=%h cyc=%0d",
                                 io_rd_w[sel], io_wr_w[sel], io_addr_w[sel], io_dout_w[sel], cyc,
                                 e.wr, e.addr, e.dout, e.cyc);
                    end
                end
            end
            if (m0_ack_w[sel] || m1_ack_w[sel]) begin
                ack_t        e;
                logic [15:0] rd;
                rd = m1_ack_w[sel] ? m1_rdata_w[sel] : m0_rdata_w[sel];
                nvec++;
                if (ackq.size() == 0) begin
                    nmis++;
                    $display("FAIL ack: unexpected ack=%b cyc %0d", {m1_ack_w[sel], m0_ack_w[sel]}, cyc);
                end else begin
                    e = ackq.pop_front();
                    if ({m1_ack_w[sel], m0_ack_w[sel]} !== e.who || grant_w[sel] !== e.who ||
                        rd !== e.rdata || cyc != e.cyc) begin
                        nmis++;
                        $display("FAIL ack: got ack=%b grant=%b rdata=%h cyc=%0d want ack=%b rdata=%h cyc=%0d",
                                 {m1_ack_w[sel], m0_ack_w[sel]}, grant_w[sel], rd, cyc,
                                 e.who, e.rdata, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        tick(2);
        #1;
        chk("reset busy", {31'b0, busy_w[0]}, 32'd0);
        chk("reset grant", {30'b0, grant_w[0]}, 32'd0);
        chk("reset rdata", {m1_rdata_w[0], m0_rdata_w[0]}, 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(2);

        // Single write by m0 (RD_LAT=1, round-robin)
        sel = 0;
        n = cyc;
        m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 16'h6702; m0_wdata = 16'h00AB;
        push_bus(1'b1, 16'h6702, 16'h00AB, n + 1);
        push_ack(2'b01, 16'h0000, n + 2);
        tick(2);
        m0_req = 1'b0;
        tick(8);

        // m1 read, RD_LAT=1; data arrives in the WAIT cycle, address change while pending ignored
        n = cyc;
        m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 16'h6904; m1_wdata = 16'h7777;
        push_bus(1'b0, 16'h6904, 16'h0000, n + 1);
        push_ack(2'b10, 16'h1234, n + 3);
        tick(2);
        io_din = 16'h1234;
        m1_addr = 16'hFFFF;
        #1;
        chk("wait addr held", {16'h0, io_addr_w[0]}, {16'h0, 16'h6904});
        chk("wait no strobe", {30'b0, io_rd_w[0], io_wr_w[0]}, 32'd0);
        chk("wait busy", {31'b0, busy_w[0]}, 32'd1);
        tick(1);
        m1_req = 1'b0; io_din = 16'hDEAD;
        tick(8);

        // Round-robin contention: both write continuously for four transactions
        n = cyc;
        m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 16'h6710; m0_wdata = 16'h1111;
        m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 16'h6820; m1_wdata = 16'h2222;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                push_bus(1'b1, 16'h6710, 16'h1111, n + 1 + 3 * k);
                push_ack(2'b01, 16'h0000, n + 2 + 3 * k);
            end else begin
                push_bus(1'b1, 16'h6820, 16'h2222, n + 1 + 3 * k);
                push_ack(2'b10, 16'h0000, n + 2 + 3 * k);
            end
        end
        tick(11);
        m0_req = 1'b0; m1_req = 1'b0;
        tick(8);

        // m0 read with RD_LAT=0: data captured in the ISSUE cycle
        sel = 1;
        n = cyc;
        m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 16'h1002;
        push_bus(1'b0, 16'h1002, 16'h0000, n + 1);
        push_ack(2'b01, 16'hBEEF, n + 2);
        tick(1);
        io_din = 16'hBEEF;
        tick(1);
        io_din = 16'hDEAD; m0_req = 1'b0;
        tick(8);

        // Fixed priority: m0 wins twice, m1 only after m0 drops
        sel = 3;
        n = cyc;
        m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 16'h6710; m0_wdata = 16'h1111;
        m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 16'h6820; m1_wdata = 16'h2222;
        push_bus(1'b1, 16'h6710, 16'h1111, n + 1);
        push_ack(2'b01, 16'h0000, n + 2);
        push_bus(1'b1, 16'h6710, 16'h1111, n + 4);
        push_ack(2'b01, 16'h0000, n + 5);
        push_bus(1'b1, 16'h6820, 16'h2222, n + 7);
        push_ack(2'b10, 16'h0000, n + 8);
        tick(5);
        m0_req = 1'b0;
        tick(3);
        m1_req = 1'b0;
        tick(8);

        // Reset in the middle of a RD_LAT=3 read: no ack, bus idle at once
        sel = 2;
        n = cyc;
        m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 16'h6A08;
        push_bus(1'b0, 16'h6A08, 16'h0000, n + 1);
        tick(3);
        #1;
        chk("pre-reset busy", {31'b0, busy_w[2]}, 32'd1);
        chk("pre-reset addr", {16'h0, io_addr_w[2]}, {16'h0, 16'h6A08});
        #1;
        rst_n = 1'b0;
        #1;
        chk("reset addr", {16'h0, io_addr_w[2]}, 32'd0);
        chk("reset grant/busy", {29'b0, grant_w[2], busy_w[2]}, 32'd0);
        chk("reset acks", {30'b0, m1_ack_w[2], m0_ack_w[2]}, 32'd0);
        m0_req = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        n = cyc;
        m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 16'h6710; m0_wdata = 16'h1111;
        m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 16'h6820; m1_wdata = 16'h2222;
        push_bus(1'b1, 16'h6710, 16'h1111, n + 1);
        push_ack(2'b01, 16'h0000, n + 2);
        tick(2);
        m0_req = 1'b0; m1_req = 1'b0;
        tick(8);

        // Back-to-back writes by m0 with new data after each ack
        sel = 0;
        n = cyc;
        m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 16'h6702; m0_wdata = 16'h0001;
        for (int k = 0; k < 3; k++) begin
            push_bus(1'b1, 16'h6702, 16'(k + 1), n + 1 + 3 * k);
            push_ack(2'b01, 16'h0000, n + 2 + 3 * k);
        end
        tick(2);
        m0_wdata = 16'h0002;
        tick(3);
        m0_wdata = 16'h0003;
        tick(3);
        m0_req = 1'b0;
        tick(10);

        chk("bus queue drained", busq.size(), 32'd0);
        chk("ack queue drained", ackq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Two-master arbiter and sequencer for the shared 16-bit peripheral I/O bus.
- Sits between the J1 CPU (master 0) and a second bus master such as a DMA or debug engine (master 1), and the address-decoded peripheral bus (mult, div, uart, lvds).
- Grants the bus to one master at a time, drives io_rd/io_wr/io_addr/io_dout, and waits a configurable read latency.
- Returns read data to the granted master with a one-cycle ack.

Parameters:
- RD_LAT, 1: read wait cycles between the io_rd strobe and io_din capture. Legal range 0..3.
- PRIO_FIXED, 0: 0 = round-robin arbitration; 1 = master 0 always wins.

Ports:
- sys_clk_i  input  1  system clock; all state changes on its rising edge.
- sys_rst_i  input  1  asynchronous, active-low reset.
- m0_req  input  1  master 0 transaction request.
- m0_wr  input  1  master 0 direction: 1 = write, 0 = read.
- m0_addr  input  16  master 0 I/O address.
- m0_wdata  input  16  master 0 write data.
- m0_ack  output  1  master 0 completion pulse.
- m0_rdata  output  16  master 0 read data; valid when m0_ack = 1.
- m1_req, m1_wr, m1_addr, m1_wdata, m1_ack, m1_rdata: same as the m0_* ports, for master 1.
- io_rd  output  1  peripheral read strobe.
- io_wr  output  1  peripheral write strobe.
- io_addr  output  16  peripheral address; bits [15:8] feed the chip-select decoder.
- io_dout  output  16  peripheral write data.
- io_din  input  16  muxed peripheral read data.
- grant  output  2  one-hot current owner: 01 = m0, 10 = m1, 00 = idle.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values (asynchronous assertion): all outputs 0, FSM = IDLE, last_grant = m1 (so m0 wins the first tie), wait counter = 0.
- Synchronous release of reset.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Sample m0_req and m1_req.
  - If neither is high, stay in IDLE.
  - If only one is high, grant it.
  - If both are high: with PRIO_FIXED = 1 grant m0; otherwise grant the master that is not last_grant.
  - On a grant: latch that master's wr/addr/wdata into internal registers, set grant, update last_grant, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - io_addr = latched address.
  - Write: io_wr = 1, io_dout = latched wdata, next state DONE.
  - Read: io_rd = 1, io_dout = 0.
    - RD_LAT = 0: capture io_din into the read-data register this cycle, next state DONE.
    - RD_LAT > 0: load counter with RD_LAT, next state WAIT.
- WAIT:
  - io_rd = 0, io_wr = 0, io_addr held (keeps chip-select and the read mux stable).
  - Counter decrements each cycle.
  - In the cycle the counter equals 1: capture io_din, next state DONE.
- DONE (1 cycle):
  - ack of the granted master = 1; its rdata = captured value (rdata = 0 for writes).
  - io_addr returns to 0.
  - Next state IDLE; grant clears on entry to IDLE.
- Latency from req sampled in IDLE to ack:
  - write: 2 cycles;
  - read: 2 + RD_LAT cycles.
- Idle time: one IDLE cycle minimum between transactions.
- Master rules:
  - Hold req and fields stable until ack.
  - req still high in the IDLE cycle after ack is a new transaction.
  - Field changes while pending are ignored, since the fields are latched at grant.
- Ungranted master: its ack stays 0 and its rdata holds its last value.
- Outputs in IDLE: io_rd = io_wr = 0, io_addr = io_dout = 0.
- io_rd and io_wr are never both high. Each is high for exactly one cycle per transaction.
- Round-robin: with both masters continuously requesting, grants alternate m0, m1, m0, … with no starvation.
- Reset mid-transaction: in-flight access is dropped, no ack is issued, and the bus returns to idle values immediately.
- rdata registers reset to 0.

Test Plan:
- Single write: m0_req, wr = 1, addr = 16'h6702, wdata = 16'h00AB -> io_wr high for 1 cycle with io_addr = 6702 and io_dout = 00AB, m0_ack 2 cycles after sampling, io_rd never high.
- Read with RD_LAT = 1: m1 reads 16'h6904, bench drives io_din = 16'h1234 one cycle after io_rd -> m1_ack with m1_rdata = 1234, 3 cycles after sampling, io_addr held at 6904 through WAIT.
- Read with RD_LAT = 0: io_din = 16'hBEEF in the ISSUE cycle -> m0_rdata = BEEF with ack 2 cycles after sampling.
- Contention, round-robin: both reqs held high for 4 transactions -> grant order m0, m1, m0, m1, each ack on the correct master only. With PRIO_FIXED = 1 -> m0 granted every time and m1 waits until m0_req drops.
- Reset mid-WAIT (RD_LAT = 3): assert sys_rst_i low during WAIT -> io_addr, grant, busy and acks go to 0 at once with no ack emitted. After release, m0 wins a simultaneous request.
- Back-to-back: m0_req held high for 3 writes -> 3 acks spaced 3 cycles apart, io_wr pulses non-overlapping.
